gemm_result_writeback: RTL and testbench

// - Consumes output tiles of the GeMM controller/MAC array: one tile per result_valid_i pulse.
// - Buffers tiles in a small FIFO and writes them to the output (C) SRAM through a req/gnt port.
// - Generates tile addresses internally: base_addr_i + tile index, row-major (m outer, n inner).
// - Signals wb_done_o once the job has finished and every buffered tile has been written.

---
 rtl/gemm_result_writeback.sv | 230 +++++++++++++++++++++++
 tb/tb_gemm_result_writeback.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_writeback.sv
// -----------------------------------------------------------------------------
// gemm_result_writeback
//
// Purpose:
//   Collects output tiles produced by the GeMM controller / MAC array, buffers
//   them in a small FIFO and writes them to the C SRAM through a req/gnt port.
//   Each tile is tagged on entry with its SRAM address: the base address
//   latched at job start plus a running tile index (row-major, m outer,
//   n inner). A one-cycle wb_done_o pulse is raised once the controller has
//   signalled job end and every buffered tile has been written.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           start of a new job: flush FIFO, zero index, clear flags,
//                     latch base_addr_i
//   job_done_i        controller done pulse (last tile may come in same cycle)
//   result_valid_i    single-cycle tile valid, no upstream backpressure
//   result_data_i     tile payload
//   base_addr_i       C base address, sampled on clear_i
//   sram_req_o        write request (FIFO not empty)
//   sram_gnt_i        grant; a write completes on req && gnt
//   sram_we_o         write enable, identical to sram_req_o
//   sram_addr_o       FIFO head address (0 when idle)
//   sram_wdata_o      FIFO head data (0 when idle)
//   busy_o            FSM is not IDLE
//   wb_done_o         one-cycle completion pulse
//   overflow_o        sticky: a tile was dropped or arrived after job end
//   fifo_level_o      registered FIFO occupancy
//   stall_cycles_o    cycles with req && !gnt (only with GEMM_WB_PERF_EN)
//
// Configuration:
//   GEMM_WB_PERF_EN   when defined, adds a saturating stall-cycle counter;
//                     otherwise stall_cycles_o is tied to 0.
// -----------------------------------------------------------------------------
module gemm_result_writeback #(
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned TileDataWidth = 512,
    parameter int unsigned FifoDepth     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           job_done_i,
    input  logic                           result_valid_i,
    input  logic [TileDataWidth-1:0]       result_data_i,
    input  logic [AddrWidth-1:0]           base_addr_i,
    output logic                           sram_req_o,
    input  logic                           sram_gnt_i,
    output logic                           sram_we_o,
    output logic [AddrWidth-1:0]           sram_addr_o,
    output logic [TileDataWidth-1:0]       sram_wdata_o,
    output logic                           busy_o,
    output logic                           wb_done_o,
    output logic                           overflow_o,
    output logic [$clog2(FifoDepth):0]     fifo_level_o,
    output logic [31:0]                    stall_cycles_o
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam int unsigned LvlWidth = PtrWidth + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LvlWidth-1:0]    count_q, count_d;
    logic [AddrWidth-1:0]   tile_idx_q, tile_idx_d;
    logic [AddrWidth-1:0]   base_q, base_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [AddrWidth-1:0]     fifo_addr_q [FifoDepth];
    logic [AddrWidth-1:0]     fifo_addr_d [FifoDepth];
    logic [TileDataWidth-1:0] fifo_data_q [FifoDepth];
    logic [TileDataWidth-1:0] fifo_data_d [FifoDepth];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic late_tile;
    logic drop_tile;

    // FIFO status and handshake decode. A pop frees a slot in the same cycle,
    // so a full FIFO can still accept a tile while the head is being written.
    always_comb begin
        full      = (count_q == LvlWidth'(FifoDepth));
        empty     = (count_q == '0);
        pop       = !empty && sram_gnt_i;
        push      = !clear_i && (state_q == ACTIVE) && result_valid_i && (!full || pop);
        drop_tile = !clear_i && (state_q == ACTIVE) && result_valid_i && full && !pop;
        late_tile = !clear_i && ((state_q == DRAIN) || (state_q == DONE)) && result_valid_i;
    end

    // Next-state logic for the FSM, pointers, tile index and sticky flag.
    // clear_i overrides everything: the FIFO is flushed by zeroing pointers.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tile_idx_d = tile_idx_q;
        base_d     = base_q;
        overflow_d = overflow_q;

        if (clear_i) begin
            state_d    = ACTIVE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            tile_idx_d = '0;
            base_d     = base_addr_i;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrWidth'(1);
                tile_idx_d = tile_idx_q + AddrWidth'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            end
            count_d = count_q + LvlWidth'(push) - LvlWidth'(pop);

            if (drop_tile || late_tile) begin
                overflow_d = 1'b1;
            end

            // DRAIN looks at the registered level, so the DONE pulse lands
            // one cycle after the last write has emptied the FIFO.
            unique case (state_q)
                IDLE:    state_d = IDLE;
                ACTIVE:  if (job_done_i) state_d = DRAIN;
                DRAIN:   if (empty) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Control registers and registered FSM outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tile_idx_q <= '0;
            base_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tile_idx_q <= tile_idx_d;
            base_q     <= base_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Tile storage. The address is formed at push time with the carry
    // discarded, so the index and the sum both wrap modulo 2^AddrWidth.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = base_q + tile_idx_q;
            fifo_data_d[wr_ptr_q] = result_data_i;
        end
    end

    // Storage needs no reset: entries are only visible once count_q says so.
    always_ff @(posedge clk_i) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    // The head is masked when empty so the write port reads as all-zero
    // whenever no request is pending, including straight out of reset.
    assign sram_req_o   = !empty;
    assign sram_we_o    = !empty;
    assign sram_addr_o  = empty ? '0 : fifo_addr_q[rd_ptr_q];
    assign sram_wdata_o = empty ? '0 : fifo_data_q[rd_ptr_q];

    assign busy_o       = busy_q;
    assign wb_done_o    = done_q;
    assign overflow_o   = overflow_q;
    assign fifo_level_o = count_q;

`ifdef GEMM_WB_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where the SRAM withholds the grant.
    always_comb begin
        stall_d = stall_q;
        if (clear_i) begin
            stall_d = '0;
        end else if (sram_req_o && !sram_gnt_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gemm_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_gemm_result_writeback
//
// Purpose:
//   Directed bench for gemm_result_writeback. The stimulus process queues the
//   expected {address, data} of every tile it knows will be written; a
//   separate monitor compares the SRAM port against the queue head whenever a
//   request is presented and pops on each completed write.
// -----------------------------------------------------------------------------
module tb_gemm_result_writeback;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 512;
    localparam int unsigned CW = 512;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          job_done_i;
    logic          result_valid_i;
    logic [DW-1:0] result_data_i;
    logic [AW-1:0] base_addr_i;
    logic          sram_req_o;
    logic          sram_gnt_i;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic          busy_o;
    logic          wb_done_o;
    logic          overflow_o;
    logic [2:0]    fifo_level_o;
    logic [31:0]   stall_cycles_o;

    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   level_peak = 0;
    exp_t exp_q[$];

    gemm_result_writeback #(
        .AddrWidth    (AW),
        .TileDataWidth(DW),
        .FifoDepth    (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .job_done_i    (job_done_i),
        .result_valid_i(result_valid_i),
        .result_data_i (result_data_i),
        .base_addr_i   (base_addr_i),
        .sram_req_o    (sram_req_o),
        .sram_gnt_i    (sram_gnt_i),
        .sram_we_o     (sram_we_o),
        .sram_addr_o   (sram_addr_o),
        .sram_wdata_o  (sram_wdata_o),
        .busy_o        (busy_o),
        .wb_done_o     (wb_done_o),
        .overflow_o    (overflow_o),
        .fifo_level_o  (fifo_level_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [CW-1:0] actual,
                                input logic [CW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of pulse inputs, then return them to idle.
    task automatic apply_stimulus(input logic clr, input logic jd, input logic vld,
                                  input logic [DW-1:0] data, input logic [AW-1:0] base);
        clear_i        = clr;
        job_done_i     = jd;
        result_valid_i = vld;
        result_data_i  = data;
        base_addr_i    = base;
        tick();
        clear_i        = 1'b0;
        job_done_i     = 1'b0;
        result_valid_i = 1'b0;
        result_data_i  = '0;
    endtask

    task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "_req"},      CW'(sram_req_o),     CW'(0));
        check_output({name, "_we"},       CW'(sram_we_o),      CW'(0));
        check_output({name, "_addr"},     CW'(sram_addr_o),    CW'(0));
        check_output({name, "_wdata"},    CW'(sram_wdata_o),   CW'(0));
        check_output({name, "_busy"},     CW'(busy_o),         CW'(0));
        check_output({name, "_done"},     CW'(wb_done_o),      CW'(0));
        check_output({name, "_overflow"}, CW'(overflow_o),     CW'(0));
        check_output({name, "_level"},    CW'(fifo_level_o),   CW'(0));
        check_output({name, "_stall"},    CW'(stall_cycles_o), CW'(0));
    endtask

    // Bounded wait for the completion pulse, then confirm return to IDLE.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (wb_done_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout actual=0 expected=1", name);
        end else begin
            tick();
            check_output({name, "_idle_busy"}, CW'(busy_o), CW'(0));
        end
    endtask

    // Monitor: every presented request must match the expected head; a grant
    // retires it. Holding the head during a stall is covered by re-checking
    // the same queue entry each stalled cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (sram_req_o && exp_q.size() > 0) begin
                check_output("wr_addr", CW'(sram_addr_o), CW'(exp_q[0].addr));
                check_output("wr_data", CW'(sram_wdata_o), CW'(exp_q[0].data));
                check_output("wr_we", CW'(sram_we_o), CW'(1));
                if (sram_gnt_i) void'(exp_q.pop_front());
            end else if (sram_req_o && sram_gnt_i) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=%0h expected=none", sram_addr_o);
            end
            if (int'(fifo_level_o) > level_peak) level_peak = int'(fifo_level_o);
            if (wb_done_o) begin
                done_count++;
                check_output("done_after_writes", CW'(exp_q.size()), CW'(0));
            end
        end
    end

    initial begin
        int done_start;
        rst_ni         = 1'b0;
        clear_i        = 1'b0;
        job_done_i     = 1'b0;
        result_valid_i = 1'b0;
        result_data_i  = '0;
        base_addr_i    = '0;
        sram_gnt_i     = 1'b0;

        // Reset with no stimulus
        #12;
        check_all_zero("in_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        tick();
        check_all_zero("after_reset");

        // Basic job: four tiles, always granted, done with the last tile
        $display("[TB] basic job");
        done_start = done_count;
        sram_gnt_i = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0100);
        check_output("basic_busy", CW'(busy_o), CW'(1));
        for (int i = 1; i <= 4; i++) begin
            expect_write(16'h0100 + AW'(i - 1), DW'(i));
            apply_stimulus(1'b0, (i == 4), 1'b1, DW'(i), 16'h0100);
        end
        wait_done("basic");
        tick();
        check_output("basic_done_pulses", CW'(done_count - done_start), CW'(1));
        check_output("basic_overflow", CW'(overflow_o), CW'(0));
        check_output("basic_queue_empty", CW'(exp_q.size()), CW'(0));

        // Backpressure: grant withheld for ten request cycles
        $display("[TB] backpressure");
        sram_gnt_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0200);
        level_peak = 0;
        for (int i = 1; i <= 3; i++) begin
            expect_write(16'h0200 + AW'(i - 1), DW'(32'hA0 + i));
            apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hA0 + i), 16'h0200);
        end
        repeat (8) tick();
        check_output("bp_level_stalled", CW'(fifo_level_o), CW'(3));
        sram_gnt_i = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 16'h0200);
        wait_done("bp");
        check_output("bp_level_peak", CW'(level_peak), CW'(3));
`ifdef GEMM_WB_PERF_EN
        check_output("bp_stall_cycles", CW'(stall_cycles_o), CW'(10));
`else
        check_output("bp_stall_cycles", CW'(stall_cycles_o), CW'(0));
`endif
        check_output("bp_overflow", CW'(overflow_o), CW'(0));

        // Overflow: five tiles into a four-entry FIFO with no grant
        $display("[TB] overflow");
        sram_gnt_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0300);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_write(16'h0300 + AW'(i - 1), DW'(32'hB0 + i));
            apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hB0 + i), 16'h0300);
        end
        check_output("ovf_flag", CW'(overflow_o), CW'(1));
        check_output("ovf_level", CW'(fifo_level_o), CW'(4));
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 16'h0300);
        tick();
        check_output("ovf_flag_drain", CW'(overflow_o), CW'(1));
        sram_gnt_i = 1'b1;
        wait_done("ovf");
        check_output("ovf_flag_sticky", CW'(overflow_o), CW'(1));
        check_output("ovf_queue_empty", CW'(exp_q.size()), CW'(0));

        // Full FIFO with a simultaneous pop still accepts the incoming tile
        $display("[TB] full plus pop");
        sram_gnt_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0400);
        check_output("clear_overflow", CW'(overflow_o), CW'(0));
        check_output("clear_stall", CW'(stall_cycles_o), CW'(0));
        for (int i = 1; i <= 4; i++) begin
            expect_write(16'h0400 + AW'(i - 1), DW'(32'hC0 + i));
            apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hC0 + i), 16'h0400);
        end
        check_output("fp_level_full", CW'(fifo_level_o), CW'(4));
        sram_gnt_i = 1'b1;
        expect_write(16'h0404, DW'(32'hC5));
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hC5), 16'h0400);
        check_output("fp_level_kept", CW'(fifo_level_o), CW'(4));
        check_output("fp_overflow", CW'(overflow_o), CW'(0));
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 16'h0400);
        wait_done("fp");
        check_output("fp_queue_empty", CW'(exp_q.size()), CW'(0));

        // Abort in DRAIN: buffered tiles flushed, new job restarts at base
        $display("[TB] abort");
        sram_gnt_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0500);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hD1), 16'h0500);
        apply_stimulus(1'b0, 1'b1, 1'b1, DW'(32'hD2), 16'h0500);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hFF), 16'h0500);
        check_output("abort_late_overflow", CW'(overflow_o), CW'(1));
        check_output("abort_level", CW'(fifo_level_o), CW'(2));
        check_output("abort_busy", CW'(busy_o), CW'(1));
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0600);
        check_output("abort_flushed", CW'(fifo_level_o), CW'(0));
        check_output("abort_req", CW'(sram_req_o), CW'(0));
        check_output("abort_active", CW'(busy_o), CW'(1));
        check_output("abort_overflow_cleared", CW'(overflow_o), CW'(0));
        sram_gnt_i = 1'b1;
        expect_write(16'h0600, DW'(32'hE1));
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hE1), 16'h0600);
        repeat (3) tick();
        check_output("abort_written", CW'(exp_q.size()), CW'(0));
        // job_done with an empty FIFO: one DRAIN cycle, then DONE
        apply_stimulus(1'b0, 1'b1, 1'b0, '0, 16'h0600);
        check_output("empty_drain_busy", CW'(busy_o), CW'(1));
        check_output("empty_drain_nodone", CW'(wb_done_o), CW'(0));
        tick();
        check_output("empty_drain_done", CW'(wb_done_o), CW'(1));
        tick();
        check_output("empty_drain_idle", CW'(busy_o), CW'(0));
        check_output("empty_drain_pulse", CW'(wb_done_o), CW'(0));

        // Asynchronous reset in the middle of a job
        $display("[TB] reset mid-job");
        sram_gnt_i = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, 16'h0700);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hF1), 16'h0700);
        apply_stimulus(1'b0, 1'b0, 1'b1, DW'(32'hF2), 16'h0700);
        tick();
        check_output("midjob_level", CW'(fifo_level_o), CW'(2));
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        check_all_zero("after_midjob_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
